// File: rtl/dac8563_pkg.sv
// rtl/dac8563_pkg.sv - DAC8563 command/address codes and frame field positions
package dac8563_pkg;

  localparam int FRAME_W = 24;

  localparam int CMD_MSB  = 21;
  localparam int CMD_LSB  = 19;
  localparam int ADDR_MSB = 18;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [2:0] CMD_WR_IN         = 3'b000;
  localparam logic [2:0] CMD_UPD_DAC       = 3'b001;
  localparam logic [2:0] CMD_WR_IN_UPD_ALL = 3'b010;
  localparam logic [2:0] CMD_WR_IN_UPD     = 3'b011;
  localparam logic [2:0] CMD_POWER         = 3'b100;
  localparam logic [2:0] CMD_SW_RESET      = 3'b101;
  localparam logic [2:0] CMD_LDAC_SETUP    = 3'b110;
  localparam logic [2:0] CMD_REFERENCE     = 3'b111;

  localparam logic [2:0] ADDR_A   = 3'b000;
  localparam logic [2:0] ADDR_B   = 3'b001;
  localparam logic [2:0] ADDR_ALL = 3'b111;

  function automatic logic addr_hits_a(input logic [2:0] addr);
    return (addr == ADDR_A) || (addr == ADDR_ALL);
  endfunction

  function automatic logic addr_hits_b(input logic [2:0] addr);
    return (addr == ADDR_B) || (addr == ADDR_ALL);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-flop synchronizer with rise/fall detect on the synchronized copy
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      dly   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      dly   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise =  q & ~dly;
  assign fall = ~q &  dly;

endmodule

// File: rtl/spi_dac8563_rx.sv
// rtl/spi_dac8563_rx.sv - oversampling DAC8563 SPI responder with shadow input/DAC registers
module spi_dac8563_rx
  import dac8563_pkg::*;
#(
  parameter int DATA_WIDTH  = FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_fRST,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_sync,
  input  logic                  i_spi_din,
  output logic                  o_frame_valid,
  output logic [DATA_WIDTH-1:0] o_frame,
  output logic [2:0]            o_cmd,
  output logic [2:0]            o_addr,
  output logic [15:0]           o_data,
  output logic [15:0]           o_dac_a,
  output logic [15:0]           o_dac_b,
  output logic                  o_update_a,
  output logic                  o_update_b,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic                   sclk_fall, sync_rise, sync_fall;
  logic                   unused_sclk_q, unused_sclk_rise, unused_sync_q;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   din;
  logic [1:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic                   frame_done;
  logic [15:0]            in_a, in_b, in_a_nx, in_b_nx;
  logic                   upd_a, upd_b, sel_a, sel_b, wr_in;
  logic [2:0]             f_cmd, f_addr;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(i_clk), .rst(i_fRST), .d(i_spi_clk),
    .q(unused_sclk_q), .rise(unused_sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(i_clk), .rst(i_fRST), .d(i_spi_sync),
    .q(unused_sync_q), .rise(sync_rise), .fall(sync_fall)
  );

  // DIN gets the same latency as SCLK so the bit is aligned with its detected edge
  always_ff @(posedge i_clk or posedge i_fRST) begin
    if (i_fRST) din_sync <= '0;
    else        din_sync <= {din_sync[SYNC_STAGES-2:0], i_spi_din};
  end
  assign din = din_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_fRST) begin
    if (i_fRST) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      frame_done  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          // SYNC rise takes priority over a coincident SCLK fall
          if (sync_rise) begin
            state       <= ST_IDLE;
            o_frame_err <= (bit_cnt != '0);
          end else if (sclk_fall) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], din};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (sync_rise)      state     <= ST_IDLE;
          else if (sclk_fall) o_overrun <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign f_cmd  = shift_reg[CMD_MSB:CMD_LSB];
  assign f_addr = shift_reg[ADDR_MSB:ADDR_LSB];

  // Software reset is folded in as "write zero to both inputs, update both"
  always_comb begin
    in_a_nx = in_a;
    in_b_nx = in_b;
    upd_a   = 1'b0;
    upd_b   = 1'b0;
    sel_a   = addr_hits_a(f_addr);
    sel_b   = addr_hits_b(f_addr);
    wr_in   = (f_cmd == CMD_WR_IN) || (f_cmd == CMD_WR_IN_UPD_ALL) || (f_cmd == CMD_WR_IN_UPD);
    if (wr_in && sel_a) in_a_nx = shift_reg[DATA_MSB:DATA_LSB];
    if (wr_in && sel_b) in_b_nx = shift_reg[DATA_MSB:DATA_LSB];
    case (f_cmd)
      CMD_UPD_DAC, CMD_WR_IN_UPD: begin
        upd_a = sel_a;
        upd_b = sel_b;
      end
      CMD_WR_IN_UPD_ALL: begin
        upd_a = 1'b1;
        upd_b = 1'b1;
      end
      CMD_SW_RESET: begin
        in_a_nx = '0;
        in_b_nx = '0;
        upd_a   = 1'b1;
        upd_b   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_fRST) begin
    if (i_fRST) begin
      o_frame_valid <= 1'b0;
      o_frame       <= '0;
      o_dac_a       <= '0;
      o_dac_b       <= '0;
      o_update_a    <= 1'b0;
      o_update_b    <= 1'b0;
      in_a          <= '0;
      in_b          <= '0;
    end else begin
      o_frame_valid <= frame_done;
      o_update_a    <= frame_done & upd_a;
      o_update_b    <= frame_done & upd_b;
      if (frame_done) begin
        o_frame <= shift_reg;
        in_a    <= in_a_nx;
        in_b    <= in_b_nx;
        if (upd_a) o_dac_a <= in_a_nx;
        if (upd_b) o_dac_b <= in_b_nx;
      end
    end
  end

  assign o_cmd  = o_frame[CMD_MSB:CMD_LSB];
  assign o_addr = o_frame[ADDR_MSB:ADDR_LSB];
  assign o_data = o_frame[DATA_MSB:DATA_LSB];
  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_dac8563_rx.sv
// tb/tb_spi_dac8563_rx.sv - scoreboard bench for spi_dac8563_rx
`timescale 1ns/1ps
module tb_spi_dac8563_rx;

  localparam int HALF = 5;

  typedef struct packed {
    logic [23:0] frame;
    logic [15:0] dac_a;
    logic [15:0] dac_b;
    logic        upd_a;
    logic        upd_b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_sync = 1'b1;
  logic        spi_din = 1'b0;
  logic        frame_valid, update_a, update_b, frame_err, overrun, busy;
  logic [23:0] frame;
  logic [2:0]  cmd, addr;
  logic [15:0] data, dac_a, dac_b;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  exp_t sb_q[$];

  logic [15:0] m_in_a, m_in_b, m_dac_a, m_dac_b;

  spi_dac8563_rx dut (
    .i_clk(clk), .i_fRST(rst), .i_spi_clk(spi_clk), .i_spi_sync(spi_sync), .i_spi_din(spi_din),
    .o_frame_valid(frame_valid), .o_frame(frame), .o_cmd(cmd), .o_addr(addr), .o_data(data),
    .o_dac_a(dac_a), .o_dac_b(dac_b), .o_update_a(update_a), .o_update_b(update_b),
    .o_frame_err(frame_err), .o_overrun(overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic model_reset();
    m_in_a = '0; m_in_b = '0; m_dac_a = '0; m_dac_b = '0;
  endtask

  // Reference behaviour of the DAC8563 register file for one complete frame
  task automatic model_push(input logic [23:0] v);
    exp_t e;
    logic [2:0] c, a;
    logic ha, hb, ua, ub;
    c = v[21:19];
    a = v[18:16];
    ha = (a == 3'd0) || (a == 3'd7);
    hb = (a == 3'd1) || (a == 3'd7);
    ua = 1'b0;
    ub = 1'b0;
    if (c == 3'b101) begin
      m_in_a = '0; m_in_b = '0; ua = 1'b1; ub = 1'b1;
    end else begin
      if ((c == 3'b000 || c == 3'b010 || c == 3'b011) && ha) m_in_a = v[15:0];
      if ((c == 3'b000 || c == 3'b010 || c == 3'b011) && hb) m_in_b = v[15:0];
      ua = (c == 3'b010) || ((c == 3'b001 || c == 3'b011) && ha);
      ub = (c == 3'b010) || ((c == 3'b001 || c == 3'b011) && hb);
    end
    if (ua) m_dac_a = m_in_a;
    if (ub) m_dac_b = m_in_b;
    e.frame = v; e.dac_a = m_dac_a; e.dac_b = m_dac_b; e.upd_a = ua; e.upd_b = ub;
    sb_q.push_back(e);
  endtask

  task automatic spi_xfer(input logic [23:0] v, input int nbits, input int extra, input bit close);
    spi_sync = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      spi_din = v[23-i];
      spi_clk = 1'b1; half();
      spi_clk = 1'b0; half();
    end
    for (int i = 0; i < extra; i++) begin
      spi_clk = 1'b1; half();
      spi_clk = 1'b0; half();
    end
    if (close) begin
      spi_sync = 1'b1;
      half(); half();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("sb_drain", sb_q.size(), 0);
  endtask

  task automatic send_frame(input logic [23:0] v, input int extra);
    model_push(v);
    spi_xfer(v, 24, extra, 1'b1);
    wait_drain();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (frame_valid) begin
        exp_t e;
        valid_cnt++;
        check_val("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_val("frame", frame, e.frame);
          check_val("cmd", cmd, e.frame[21:19]);
          check_val("addr", addr, e.frame[18:16]);
          check_val("data", data, e.frame[15:0]);
          check_val("dac_a", dac_a, e.dac_a);
          check_val("dac_b", dac_b, e.dac_b);
          check_val("upd_a", update_a, e.upd_a);
          check_val("upd_b", update_b, e.upd_b);
        end
      end else if (update_a || update_b) begin
        check_val("stray_upd", {update_a, update_b}, 0);
      end
    end
  end

  initial begin
    int e0, v0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_frame", frame, 0);
    check_val("rst_dac_a", dac_a, 0);
    check_val("rst_dac_b", dac_b, 0);
    check_val("rst_flags", {frame_valid, update_a, update_b, frame_err, overrun, busy}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(24'h188000, 0);
    send_frame(24'h074000, 0);
    send_frame(24'h0F0000, 0);
    check_val("no_overrun", overrun, 0);

    e0 = err_cnt; v0 = valid_cnt;
    spi_xfer(24'hABCDEF, 10, 0, 1'b1);
    repeat (20) @(negedge clk);
    check_val("abort_err", err_cnt - e0, 1);
    check_val("abort_valid", valid_cnt - v0, 0);
    check_val("abort_dac_a", dac_a, m_dac_a);
    check_val("abort_dac_b", dac_b, m_dac_b);

    send_frame(24'h198000, 3);
    check_val("overrun_set", overrun, 1);
    send_frame(24'h181234, 0);
    check_val("overrun_sticky", overrun, 1);
    send_frame(24'h280000, 0);
    check_val("swrst_dac_a", dac_a, 0);
    check_val("swrst_dac_b", dac_b, 0);

    e0 = err_cnt;
    spi_xfer(24'h18FFFF, 12, 0, 1'b0);
    check_val("busy_mid", busy, 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_val("mrst_frame", frame, 0);
    check_val("mrst_flags", {frame_valid, update_a, update_b, frame_err, overrun, busy}, 0);
    check_val("mrst_dacs", {dac_a, dac_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    half();
    spi_sync = 1'b1;
    half(); half();
    check_val("mrst_no_err", err_cnt - e0, 0);
    send_frame(24'h18FFFF, 0);
    check_val("final_dac_a", dac_a, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
